// File: rtl/pdm_des_if.sv
// Word-output bundle of the PDM deserializer.
//
// Handshake: the producer raises valid_o while data_o holds a word that
// has not been taken yet. A word is taken on any rising clock edge where
// valid_o=1 and ready_i=1. The producer may replace data_o while valid_o=1.
// Newest word wins, and a replaced word that was never taken raises the
// sticky overrun_o. overrun_o stays high until clr_ovr_i clears it.
// done_o pulses for one cycle per completed word, whether or not it is taken.
interface pdm_des_if #(
    parameter int C_NR_OF_BITS = 16
);
    logic [C_NR_OF_BITS-1:0] data_o;
    logic                    done_o;
    logic                    valid_o;
    logic                    ready_i;
    logic                    overrun_o;
    logic                    clr_ovr_i;

    // Producer side (the deserializer).
    modport master (
        output data_o,
        output done_o,
        output valid_o,
        output overrun_o,
        input  ready_i,
        input  clr_ovr_i
    );

    // Consumer side.
    modport slave (
        input  data_o,
        input  done_o,
        input  valid_o,
        input  overrun_o,
        output ready_i,
        output clr_ovr_i
    );
endinterface

// File: rtl/pdm_des.sv
// PDM microphone deserializer.
// Generates the microphone clock and samples the synchronized PDM stream
// once per microphone clock period, one clk_i cycle after each rising edge.
// It packs C_NR_OF_BITS samples MSB-first into a word. Each completed word is
// presented on a valid/ready output with sticky overrun detection.
module pdm_des #(
    parameter int C_NR_OF_BITS       = 16,
    parameter int C_SYS_CLK_FREQ_MHZ = 100,
    parameter int C_PDM_FREQ_MHZ     = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic       pdm_m_clk_o,
    input  logic       pdm_m_data_i,
    output logic       pdm_lrsel_o,
    pdm_des_if.master  word_if
);

    // Half period of the microphone clock, in clk_i cycles.
    localparam int HALF  = C_SYS_CLK_FREQ_MHZ / (C_PDM_FREQ_MHZ * 2);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BIT_W = $clog2(C_NR_OF_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(C_NR_OF_BITS - 1);

    // Two-flop synchronizer for the asynchronous microphone data.
    logic [1:0]             sync_q;
    logic                   data_sync;

    // Microphone clock divider and its one-cycle-delayed copy.
    logic [CNT_W-1:0]       cnt_clk;
    logic                   clk_int;
    logic                   clk_intt;
    logic                   rise;

    // Only the low N-1 sample bits need storing. The newest sample is
    // appended when the word completes.
    logic [C_NR_OF_BITS-2:0] shreg;
    logic [C_NR_OF_BITS-1:0] shreg_full;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    complete;

    // Output-side registers, mirrored onto the interface.
    logic [C_NR_OF_BITS-1:0] data_q;
    logic                    done_q;
    logic                    valid_q;
    logic                    overrun_q;

    assign data_sync   = sync_q[1];
    assign rise        = clk_int & ~clk_intt;
    assign shreg_full  = {shreg, data_sync};
    assign complete    = en_i & rise & (bit_cnt == BIT_LAST);

    assign pdm_m_clk_o = clk_int;
    assign pdm_lrsel_o = 1'b0;

    assign word_if.data_o    = data_q;
    assign word_if.done_o    = done_q;
    assign word_if.valid_o   = valid_q;
    assign word_if.overrun_o = overrun_q;

    // Synchronize the microphone data. This runs regardless of enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pdm_m_data_i};
        end
    end

    // Divide clk_i down to the microphone clock. Each phase lasts HALF cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_clk <= '0;
            clk_int <= 1'b0;
        end else if (!en_i) begin
            cnt_clk <= '0;
            clk_int <= 1'b0;
        end else if (cnt_clk == CNT_LAST) begin
            cnt_clk <= '0;
            clk_int <= ~clk_int;
        end else begin
            cnt_clk <= cnt_clk + CNT_W'(1);
        end
    end

    // Delay the microphone clock one cycle so its rising edge is a single-cycle event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_intt <= 1'b0;
        end else if (!en_i) begin
            clk_intt <= 1'b0;
        end else begin
            clk_intt <= clk_int;
        end
    end

    // Shift in one sample per rise event. Disabling discards the partial word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (!en_i) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (rise) begin
            shreg   <= shreg_full[C_NR_OF_BITS-2:0];
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        end
    end

    // Pulse done for the cycle after a word completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= complete;
        end
    end

    // Capture the completed word. Otherwise data_o holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (complete) begin
            data_q <= shreg_full;
        end
    end

    // Valid is set by a completion and cleared when the consumer takes the word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (complete) begin
            valid_q <= 1'b1;
        end else if (valid_q && word_if.ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Overrun is set when an untaken word is replaced. If set and clear coincide, set wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_q <= 1'b0;
        end else if (complete && valid_q && !word_if.ready_i) begin
            overrun_q <= 1'b1;
        end else if (word_if.clr_ovr_i) begin
            overrun_q <= 1'b0;
        end
    end

endmodule

// File: doc/pdm_des.md
PDM_DES -- requirements
Module: pdm_des

Interface
REQ-001 SHALL have parameter C_NR_OF_BITS, default 16, word width in PDM bits (range 2..32).
REQ-002 SHALL have parameter C_SYS_CLK_FREQ_MHZ, default 100, clk_i frequency.
REQ-003 SHALL have parameter C_PDM_FREQ_MHZ, default 3, target microphone clock frequency; HALF = C_SYS_CLK_FREQ_MHZ/(C_PDM_FREQ_MHZ*2), integer division, HALF >= 2 (16 at defaults).
REQ-004 SHALL have clk_i  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have en_i  input  1  capture enable.
REQ-007 SHALL have pdm_m_clk_o  output  1  clock to microphone.
REQ-008 SHALL have pdm_m_data_i  input  1  PDM data from microphone, asynchronous to clk_i.
REQ-009 SHALL have pdm_lrsel_o  output  1  channel select, constant 0.
REQ-010 SHALL have data_o  output  C_NR_OF_BITS  last completed word, MSB = first sampled bit.
REQ-011 SHALL have done_o  output  1  one-cycle pulse per completed word.
REQ-012 SHALL have valid_o  output  1  data_o holds an unconsumed word.
REQ-013 SHALL have ready_i  input  1  consumer accepts data_o when valid_o=1.
REQ-014 SHALL have overrun_o  output  1  sticky: a word was overwritten before being accepted.
REQ-015 SHALL have clr_ovr_i  input  1  clears overrun_o.

Function
REQ-016 SHALL pass pdm_m_data_i through two clk_i flops (data_sync) before any use.
REQ-017 SHALL run divider cnt_clk 0..HALF-1 while en_i=1; at HALF-1, cnt_clk<=0 and clk_int toggles; pdm_m_clk_o = clk_int (registered, 50% duty, period 2*HALF cycles).
REQ-018 SHALL register clk_int into clk_intt every cycle; rise event = clk_int=1 and clk_intt=0 (exactly one clk_i cycle per PDM period).
REQ-019 SHALL, while en_i=0, hold cnt_clk=0, clk_int=0, clk_intt=0, bit counter=0, shift register=0; data_o, valid_o, overrun_o retained.
REQ-020 SHALL, on each rise event, shift shreg <= {shreg[N-2:0], data_sync} and advance bit counter modulo C_NR_OF_BITS.
REQ-021 SHALL, on the rise event where bit counter = N-1, load data_o <= {shreg[N-2:0], data_sync}, set valid_o, and assert done_o for exactly the following cycle.
REQ-022 SHALL clear valid_o on a cycle with valid_o=1 and ready_i=1 and no completion.
REQ-023 SHALL, on completion with valid_o=1 and ready_i=1 in the same cycle, keep valid_o=1, load the new word, and not set overrun_o.
REQ-024 SHALL, on completion with valid_o=1 and ready_i=0, overwrite data_o (newest wins), keep valid_o=1, and set overrun_o.
REQ-025 SHALL clear overrun_o on clr_ovr_i=1; simultaneous set and clear: set wins.
REQ-026 SHALL hold data_o stable except on completion.
REQ-027 SHALL drive pdm_lrsel_o = 0 at all times, including reset.

Reset
REQ-028 SHALL, while rst_i=1, immediately force cnt_clk=0, clk_int=0, clk_intt=0, sync flops=0, shreg=0, bit counter=0, data_o=0, done_o=0, valid_o=0, overrun_o=0.
REQ-029 SHALL, after rst_i deasserts with en_i=1, produce the first pdm_m_clk_o rise HALF cycles later and the first sample on the rise event one cycle after that.
REQ-030 SHALL discard any partial word on reset or en_i deassertion; the next word consists of N fresh samples.

Verification
REQ-031 Reset: assert rst_i mid-word asynchronously -> all outputs 0 without a clock edge; pdm_m_clk_o low.
REQ-032 Clock: defaults, en_i=1 after reset -> pdm_m_clk_o period 32 cycles, high 16/low 16, first rise 16 cycles after reset release.
REQ-033 Capture: mic model drives 16'hA5C3 MSB-first, bit changes on PDM falling edge -> after 16th rise event data_o=16'hA5C3, valid_o=1, done_o high one cycle.
REQ-034 Handshake/overrun: ready_i=0 over words 16'h1234 then 16'hFFFF -> data_o=16'hFFFF, overrun_o=1; clr_ovr_i pulse -> overrun_o=0; ready_i=1 -> valid_o=0 next cycle.
REQ-035 Simultaneous: ready_i=1 in the completion cycle of word 16'h00FF while valid_o=1 -> data_o=16'h00FF, valid_o=1, overrun_o stays 0.
REQ-036 Enable drop: en_i=0 after 5 bits, re-enable, drive 16'h8001 -> pdm_m_clk_o low while disabled; next data_o=16'h8001.
